// File: rtl/jogador_pkg.sv
// jogador_pkg: state codes, result codes and default timing for the automatic game player
package jogador_pkg;
  typedef enum logic [3:0] {
    INICIAL       = 4'd0,
    PULSO_INICIAR = 4'd1,
    ESPERA_INICIO = 4'd2,
    PRESSIONA     = 4'd3,
    SOLTA         = 4'd4,
    AGUARDA_FIM   = 4'd5,
    FIM           = 4'd6
  } estado_t;
  localparam logic [1:0] RES_NENHUM  = 2'b00;
  localparam logic [1:0] RES_ACERTOU = 2'b01;
  localparam logic [1:0] RES_ERROU   = 2'b10;
  localparam logic [1:0] RES_AMBOS   = 2'b11;
  localparam int T_INICIAR_DEF   = 5;
  localparam int T_PRESS_DEF     = 10;
  localparam int T_GAP_DEF       = 10;
  localparam int NUM_JOGADAS_DEF = 16;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/rom_jogadas_16x4.sv
// rom_jogadas_16x4: fixed 16-move one-hot sequence replayed on chaves
module rom_jogadas_16x4 (
  input  logic [3:0] addr,
  output logic [3:0] data
);
  always_comb begin
    data = 4'b0000;
    case (addr)
      4'd0:  data = 4'b0001;
      4'd1:  data = 4'b0010;
      4'd2:  data = 4'b0100;
      4'd3:  data = 4'b1000;
      4'd4:  data = 4'b0100;
      4'd5:  data = 4'b0010;
      4'd6:  data = 4'b0001;
      4'd7:  data = 4'b0001;
      4'd8:  data = 4'b0010;
      4'd9:  data = 4'b0010;
      4'd10: data = 4'b0100;
      4'd11: data = 4'b0100;
      4'd12: data = 4'b1000;
      4'd13: data = 4'b1000;
      4'd14: data = 4'b0001;
      4'd15: data = 4'b0100;
    endcase
  end
endmodule

// File: rtl/jogador_automatico.sv
// jogador_automatico: replays a fixed move sequence into the memory game and latches its result
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int T_INICIAR   = T_INICIAR_DEF,
  parameter int T_PRESS     = T_PRESS_DEF,
  parameter int T_GAP       = T_GAP_DEF,
  parameter int NUM_JOGADAS = NUM_JOGADAS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       disparar,
  input  logic       pronto,
  input  logic       acertou,
  input  logic       errou,
  output logic       iniciar_out,
  output logic [3:0] chaves,
  output logic       ativo,
  output logic       concluido,
  output logic [1:0] resultado,
  output logic [3:0] db_estado,
  output logic [3:0] db_jogada
);
  localparam int TW = $clog2(max3(T_INICIAR, T_PRESS, T_GAP) + 1);
  estado_t estado, proximo;
  logic [TW-1:0] timer;
  logic [3:0] indice, indice_prox, rom_dado;
  rom_jogadas_16x4 u_rom (.addr(indice_prox), .data(rom_dado));
  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:       proximo = disparar ? PULSO_INICIAR : INICIAL;
      PULSO_INICIAR: proximo = (timer == TW'(T_INICIAR - 1)) ? ESPERA_INICIO : PULSO_INICIAR;
      ESPERA_INICIO: proximo = pronto ? FIM : (timer == TW'(T_GAP - 1)) ? PRESSIONA : ESPERA_INICIO;
      PRESSIONA:     proximo = pronto ? FIM : (timer == TW'(T_PRESS - 1)) ? SOLTA : PRESSIONA;
      SOLTA:         proximo = pronto ? FIM : (timer != TW'(T_GAP - 1)) ? SOLTA :
                               (indice == 4'(NUM_JOGADAS - 1)) ? AGUARDA_FIM : PRESSIONA;
      AGUARDA_FIM:   proximo = pronto ? FIM : AGUARDA_FIM;
      FIM:           proximo = disparar ? PULSO_INICIAR : FIM;
      default:       proximo = INICIAL;
    endcase
  end
  // the ROM is addressed with the next index so chaves lands on the same edge the move starts
  assign indice_prox = (proximo == INICIAL || proximo == PULSO_INICIAR) ? 4'd0 :
                       (estado == SOLTA && proximo == PRESSIONA) ? indice + 4'd1 : indice;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= INICIAL;
      timer       <= '0;
      indice      <= '0;
      iniciar_out <= 1'b0;
      chaves      <= 4'b0000;
      ativo       <= 1'b0;
      concluido   <= 1'b0;
      resultado   <= RES_NENHUM;
      db_estado   <= 4'd0;
      db_jogada   <= 4'd0;
    end else begin
      estado      <= proximo;
      timer       <= (proximo != estado || proximo == INICIAL || proximo == AGUARDA_FIM || proximo == FIM) ?
                     '0 : timer + 1'b1;
      indice      <= indice_prox;
      iniciar_out <= proximo == PULSO_INICIAR;
      chaves      <= (proximo == PRESSIONA) ? rom_dado : 4'b0000;
      ativo       <= proximo == PULSO_INICIAR || proximo == ESPERA_INICIO || proximo == PRESSIONA ||
                     proximo == SOLTA || proximo == AGUARDA_FIM;
      concluido   <= proximo == FIM;
      resultado   <= (proximo == PULSO_INICIAR && estado != PULSO_INICIAR) ? RES_NENHUM :
                     (proximo == FIM && estado != FIM) ? {errou, acertou} : resultado;
      db_estado   <= proximo;
      db_jogada   <= indice_prox;
    end
  end
endmodule
